// File: rtl/uart_cmd_parser.sv
// Assembles 6-byte SYNC/ADDR/CMD/DHI/DLO/CHK frames from a UART receiver
// and presents XOR-verified commands on a valid/ready interface.
module uart_cmd_parser #(
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter int         TIMEOUT_CYC = 100000,
   parameter int         TO_W        = 17
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_done_tick,
   input  logic        cmd_ready,
   output logic        cmd_valid,
   output logic [7:0]  cmd_addr,
   output logic [7:0]  cmd_code,
   output logic [15:0] cmd_data,
   output logic        frame_err,
   output logic [1:0]  err_code,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_CMD,
      S_DHI,
      S_DLO,
      S_CHK
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   state_t          r_state;
   state_t          w_next_state;
   logic [7:0]      r_addr;
   logic [7:0]      r_cmd;
   logic [7:0]      r_dhi;
   logic [7:0]      r_dlo;
   logic [7:0]      r_chk;
   logic [TO_W-1:0] r_to_cnt;
   logic            w_good;
   logic            w_bad;
   logic            w_timeout;
   logic            w_overrun;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_good       = 1'b0;
      w_bad        = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         S_IDLE: if (rx_done_tick && rx_data == SYNC_BYTE) w_next_state = S_ADDR;
         S_ADDR: if (rx_done_tick) w_next_state = S_CMD;
         S_CMD:  if (rx_done_tick) w_next_state = S_DHI;
         S_DHI:  if (rx_done_tick) w_next_state = S_DLO;
         S_DLO:  if (rx_done_tick) w_next_state = S_CHK;
         S_CHK: begin
            if (rx_done_tick) begin
               w_next_state = S_IDLE;
               w_good       = (rx_data == r_chk);
               w_bad        = (rx_data != r_chk);
            end
         end
         default: w_next_state = S_IDLE;
      endcase
      // A byte arriving in the final timeout cycle takes priority over the timeout.
      if (r_state != S_IDLE && !rx_done_tick && r_to_cnt == TO_LAST) begin
         w_next_state = S_IDLE;
         w_timeout    = 1'b1;
      end
   end

   assign w_overrun = w_good && cmd_valid && !cmd_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr    <= '0;
         r_cmd     <= '0;
         r_dhi     <= '0;
         r_dlo     <= '0;
         r_chk     <= '0;
         r_to_cnt  <= '0;
         cmd_valid <= 1'b0;
         cmd_addr  <= '0;
         cmd_code  <= '0;
         cmd_data  <= '0;
         frame_err <= 1'b0;
         err_code  <= '0;
         busy      <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         busy      <= (w_next_state != S_IDLE);

         if (rx_done_tick || w_next_state == S_IDLE) begin
            r_to_cnt <= '0;
         end else if (r_to_cnt != '1) begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end

         if (rx_done_tick) begin
            case (r_state)
               S_IDLE: if (rx_data == SYNC_BYTE) r_chk <= '0;
               S_ADDR: begin r_addr <= rx_data; r_chk <= r_chk ^ rx_data; end
               S_CMD:  begin r_cmd  <= rx_data; r_chk <= r_chk ^ rx_data; end
               S_DHI:  begin r_dhi  <= rx_data; r_chk <= r_chk ^ rx_data; end
               S_DLO:  begin r_dlo  <= rx_data; r_chk <= r_chk ^ rx_data; end
               default: ;
            endcase
         end

         if (w_good && !w_overrun) begin
            cmd_valid <= 1'b1;
            cmd_addr  <= r_addr;
            cmd_code  <= r_cmd;
            cmd_data  <= {r_dhi, r_dlo};
         end else if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
         end

         if (w_bad) begin
            frame_err <= 1'b1;
            err_code  <= 2'b01;
         end else if (w_overrun) begin
            frame_err <= 1'b1;
            err_code  <= 2'b11;
         end else if (w_timeout) begin
            frame_err <= 1'b1;
            err_code  <= 2'b10;
         end
      end
   end

endmodule
